// File: rtl/handshake_data_mem_pkg.sv
// Shared types and helpers for the handshake data memory.
// Holds the controller state encoding and latency counter sizing.
package mem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int MAX_LATENCY = 8;

    function automatic int clog2_lat(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/handshake_data_mem_if.sv
// Request/response channel bundle for the data memory.
// rsp_err only exists when MEM_RANGE_CHECK_EN is defined.
interface handshake_data_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              clr_busy;
`ifdef MEM_RANGE_CHECK_EN
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, clr_busy, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, clr_busy, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, clr_busy
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, clr_busy
    );
`endif
endinterface

// File: rtl/handshake_data_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, registered read.
// Writes are blocked while rst is high so reset wins over any access.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && !rst) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/handshake_data_mem.sv
// Valid/ready data memory with post-reset clear sweep and fixed latency.
// Define MEM_RANGE_CHECK_EN to flag out-of-range addresses via rsp_err.
module handshake_data_mem
    import mem_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input logic                clk,
    input logic                rst,
    handshake_data_mem_if.slave bus
);
    localparam int CNT_W = clog2_lat(LATENCY);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_lat
        $error("LATENCY out of range");
    end

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              in_rng;
    logic              use_mem_q;
    logic [DATA_W-1:0] data_q;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;
    assign in_rng      = 32'(bus.req_addr) < DEPTH;
    assign idx         = bus.req_addr;
    assign bus.rsp_err = err_q;
`else
    assign in_rng = 1'b1;
    assign idx    = ADDR_W'(32'(bus.req_addr) % DEPTH);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.clr_busy  = 1'b0;
        accept        = 1'b0;
        arr_we        = 1'b0;
        arr_re        = 1'b0;
        arr_addr      = idx;
        arr_wdata     = bus.req_wdata;
        unique case (state)
            CLEAR: begin
                bus.clr_busy = 1'b1;
                arr_we       = 1'b1;
                arr_addr     = clr_ptr;
                arr_wdata    = '0;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) state_n = IDLE;
            end
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    arr_we  = bus.req_we && in_rng;
                    arr_re  = !bus.req_we && in_rng;
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) state_n = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = CLEAR;
        endcase
    end

    // Writes echo their data; reads pick up the array's registered port.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr   <= '0;
            cnt       <= '0;
            data_q    <= '0;
            use_mem_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            if (state == CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
            if (accept) begin
                cnt       <= CNT_W'(LATENCY - 1);
                data_q    <= bus.req_we ? bus.req_wdata : '0;
                use_mem_q <= !bus.req_we && in_rng;
`ifdef MEM_RANGE_CHECK_EN
                err_q     <= !in_rng;
`endif
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign bus.rsp_rdata = use_mem_q ? arr_rdata : data_q;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );
endmodule
